// File: rtl/dac_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dac_tx_pkg
//  Description : Shared types, width helpers, term-disable rule and output
//                saturation for the time-multiplexed DAC transmit mixer.
//  Revision    : 1.0 - initial release
// ============================================================================
package dac_tx_pkg;

  // Sequencer states: waiting for a sample, stepping terms, flushing the MAC
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } tx_state_t;

  localparam int c_PCM_W        = 16;
  localparam int c_DRAIN_CYCLES = 2;

  // Width of one I*cos or Q*sin product
  function automatic int prod_width(input int sita_w);
    return c_PCM_W + sita_w;
  endfunction

  // Width of one I*cos - Q*sin term (one guard bit for the subtraction)
  function automatic int term_width(input int sita_w);
    return c_PCM_W + 1 + sita_w;
  endfunction

  // Accumulator width: one term plus growth for MIX_NUM terms
  function automatic int acc_width(input int sita_w, input int mix_num);
    return term_width(sita_w) + $clog2(mix_num);
  endfunction

  // A choose value outside the frequency range switches the term off
  function automatic logic term_enabled(input logic [3:0] sel, input int freq_num);
    return (int'({28'd0, sel}) < freq_num);
  endfunction

  // Clamp to 16-bit signed; bit 16 flags that clipping happened
  function automatic logic [16:0] saturate_pcm(input logic signed [63:0] v);
    if (v > 64'sd32767)
      return {1'b1, 16'h7FFF};
    else if (v < -64'sd32768)
      return {1'b1, 16'h8000};
    else
      return {1'b0, v[15:0]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/tx_mac.sv
`default_nettype none
// ============================================================================
//  Module      : tx_mac
//  Description : Registered I/Q multiplier pair, I*cos - Q*sin subtractor and
//                accumulator that reloads on the first term of each channel.
//                Sideband tags travel alongside the data.
//  Revision    : 1.0 - initial release
// ============================================================================
module tx_mac
  import dac_tx_pkg::*;
#(
  parameter int SITA_W = 16,
  parameter int ACC_W  = acc_width(16, 3),
  parameter int TAG_W  = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_vld,
  input  logic                     i_first,
  input  logic                     i_last,
  input  logic [TAG_W-1:0]         i_tag,
  input  logic signed [15:0]       i_i,
  input  logic signed [15:0]       i_q,
  input  logic signed [SITA_W-1:0] i_cos,
  input  logic signed [SITA_W-1:0] i_sin,
  output logic signed [ACC_W-1:0]  o_acc,
  output logic                     o_done,
  output logic [TAG_W-1:0]         o_tag
);

  localparam int PROD_W = prod_width(SITA_W);
  localparam int TERM_W = term_width(SITA_W);

  logic signed [PROD_W-1:0] r_prod_i;
  logic signed [PROD_W-1:0] r_prod_q;
  logic                     r_vld1;
  logic                     r_first1;
  logic                     r_last1;
  logic [TAG_W-1:0]         r_tag1;
  logic signed [TERM_W-1:0] w_term;
  logic signed [ACC_W-1:0]  r_acc;
  logic                     r_done;
  logic [TAG_W-1:0]         r_tag2;

  // Stage 1: register both products and the term's sideband
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prod_i <= '0;
      r_prod_q <= '0;
      r_vld1   <= 1'b0;
      r_first1 <= 1'b0;
      r_last1  <= 1'b0;
      r_tag1   <= '0;
    end else begin
      r_prod_i <= PROD_W'(i_i) * PROD_W'(i_cos);
      r_prod_q <= PROD_W'(i_q) * PROD_W'(i_sin);
      r_vld1   <= i_vld;
      r_first1 <= i_first;
      r_last1  <= i_last;
      r_tag1   <= i_tag;
    end
  end

  // Term value from the registered products
  always_comb begin
    w_term = TERM_W'(r_prod_i) - TERM_W'(r_prod_q);
  end

  // Stage 2: accumulate, restarting on the first term of each channel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc  <= '0;
      r_done <= 1'b0;
      r_tag2 <= '0;
    end else begin
      if (r_vld1) begin
        r_acc <= r_first1 ? ACC_W'(w_term) : r_acc + ACC_W'(w_term);
      end
      r_done <= r_vld1 & r_last1;
      r_tag2 <= r_tag1;
    end
  end

  assign o_acc  = r_acc;
  assign o_done = r_done;
  assign o_tag  = r_tag2;

endmodule
`default_nettype wire

// File: rtl/dac_tx_tdm.sv
`default_nettype none
// ============================================================================
//  Module      : dac_tx_tdm
//  Description : Time-multiplexed transmit mixer. Each channel output is the
//                scaled, saturated sum of MIX_NUM selected I*cos - Q*sin terms,
//                evaluated one term per cycle on a shared MAC.
//  Revision    : 1.0 - initial release
// ============================================================================
module dac_tx_tdm
  import dac_tx_pkg::*;
#(
  parameter int CHANNEL  = 8,
  parameter int FREQ_NUM = 6,
  parameter int MIX_NUM  = 3,
  parameter int SITA_W   = 16
) (
  input  logic                              da_clk,
  input  logic                              rst,
  input  logic [16*FREQ_NUM-1:0]            ipcm_in,
  input  logic [16*FREQ_NUM-1:0]            qpcm_in,
  input  logic                              iqpcm_valid,
  input  logic [SITA_W*MIX_NUM*CHANNEL-1:0] cos_sita,
  input  logic [SITA_W*MIX_NUM*CHANNEL-1:0] sin_sita,
  input  logic [4*MIX_NUM*CHANNEL-1:0]      choose,
  input  logic [CHANNEL-1:0]                err_clr,
  output logic [16*CHANNEL-1:0]             dac_pcm_out,
  output logic [CHANNEL-1:0]                dac_pcm_out_valid,
  output logic [CHANNEL-1:0]                err,
  output logic                              busy
);

  localparam int N_TERMS = CHANNEL * MIX_NUM;
  localparam int KW      = $clog2(N_TERMS + 1);
  localparam int CW      = (CHANNEL > 1) ? $clog2(CHANNEL) : 1;
  localparam int MW      = (MIX_NUM > 1) ? $clog2(MIX_NUM) : 1;
  localparam int ACC_W   = acc_width(SITA_W, MIX_NUM);

  tx_state_t r_state;
  tx_state_t w_state_nxt;

  logic [KW-1:0] r_k;
  logic [MW-1:0] r_m;
  logic [CW-1:0] r_c;
  logic          w_last_term;
  logic          w_drain_done;
  logic          w_accept;
  logic          w_overrun;
  logic          w_term_vld;

  logic [16*FREQ_NUM-1:0]            r_ipcm;
  logic [16*FREQ_NUM-1:0]            r_qpcm;
  logic [SITA_W*MIX_NUM*CHANNEL-1:0] r_cos;
  logic [SITA_W*MIX_NUM*CHANNEL-1:0] r_sin;
  logic [4*MIX_NUM*CHANNEL-1:0]      r_choose;

  logic [3:0]               w_sel;
  logic signed [SITA_W-1:0] w_cos;
  logic signed [SITA_W-1:0] w_sin;
  logic signed [15:0]       w_i;
  logic signed [15:0]       w_q;

  logic signed [ACC_W-1:0]  w_acc;
  logic                     w_done;
  logic [CW-1:0]            w_done_ch;
  logic signed [ACC_W-1:0]  w_shift;
  logic [16:0]              w_sat;
  logic [CHANNEL-1:0]       w_err_set;

  logic [16*CHANNEL-1:0]    r_out;
  logic [CHANNEL-1:0]       r_out_vld;
  logic [CHANNEL-1:0]       r_err;

  assign w_last_term  = (r_state == ST_RUN)   && (r_k == KW'(N_TERMS - 1));
  assign w_drain_done = (r_state == ST_DRAIN) && (r_k == KW'(c_DRAIN_CYCLES - 1));

  // State register
  always_ff @(posedge da_clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state: accept in IDLE, step all terms, then flush the MAC pipeline
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (iqpcm_valid)  w_state_nxt = ST_RUN;
      ST_RUN:   if (w_last_term)  w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_drain_done) w_state_nxt = ST_IDLE;
      default:                    w_state_nxt = ST_IDLE;
    endcase
  end

  // State-derived controls; a valid outside IDLE is an overrun and is dropped
  always_comb begin
    w_accept   = (r_state == ST_IDLE) && iqpcm_valid;
    w_overrun  = (r_state != ST_IDLE) && iqpcm_valid;
    w_term_vld = (r_state == ST_RUN);
    busy       = (r_state != ST_IDLE);
  end

  // Term counter k and its (channel, mix) split; reused as the drain timer
  always_ff @(posedge da_clk or posedge rst) begin
    if (rst) begin
      r_k <= '0;
      r_m <= '0;
      r_c <= '0;
    end else if ((r_state == ST_IDLE) || w_last_term || w_drain_done) begin
      r_k <= '0;
      r_m <= '0;
      r_c <= '0;
    end else begin
      r_k <= r_k + KW'(1);
      if (r_state == ST_RUN) begin
        if (r_m == MW'(MIX_NUM - 1)) begin
          r_m <= '0;
          r_c <= r_c + CW'(1);
        end else begin
          r_m <= r_m + MW'(1);
        end
      end
    end
  end

  // Shadow the sample and configuration so later input changes are ignored
  always_ff @(posedge da_clk or posedge rst) begin
    if (rst) begin
      r_ipcm   <= '0;
      r_qpcm   <= '0;
      r_cos    <= '0;
      r_sin    <= '0;
      r_choose <= '0;
    end else if (w_accept) begin
      r_ipcm   <= ipcm_in;
      r_qpcm   <= qpcm_in;
      r_cos    <= cos_sita;
      r_sin    <= sin_sita;
      r_choose <= choose;
    end
  end

  // Per-term coefficient and choose selection
  always_comb begin
    w_sel = '0;
    w_cos = '0;
    w_sin = '0;
    for (int t = 0; t < N_TERMS; t++) begin
      if (r_k == KW'(t)) begin
        w_sel = r_choose[4*t +: 4];
        w_cos = r_cos[SITA_W*t +: SITA_W];
        w_sin = r_sin[SITA_W*t +: SITA_W];
      end
    end
  end

  // Frequency component mux; a disabled term feeds zeros so it adds nothing
  always_comb begin
    w_i = '0;
    w_q = '0;
    if (term_enabled(w_sel, FREQ_NUM)) begin
      for (int f = 0; f < FREQ_NUM; f++) begin
        if (w_sel == 4'(f)) begin
          w_i = r_ipcm[16*f +: 16];
          w_q = r_qpcm[16*f +: 16];
        end
      end
    end
  end

  tx_mac #(
    .SITA_W (SITA_W),
    .ACC_W  (ACC_W),
    .TAG_W  (CW)
  ) u_mac (
    .clk     (da_clk),
    .rst     (rst),
    .i_vld   (w_term_vld),
    .i_first (r_m == '0),
    .i_last  (r_m == MW'(MIX_NUM - 1)),
    .i_tag   (r_c),
    .i_i     (w_i),
    .i_q     (w_q),
    .i_cos   (w_cos),
    .i_sin   (w_sin),
    .o_acc   (w_acc),
    .o_done  (w_done),
    .o_tag   (w_done_ch)
  );

  // Scale back from Q1.(SITA_W-1) with floor rounding, then clamp to 16 bits
  always_comb begin
    w_shift = w_acc >>> (SITA_W - 1);
    w_sat   = saturate_pcm(64'(w_shift));
  end

  // Error sources: overrun hits every channel, clipping hits its own channel
  always_comb begin
    w_err_set = w_overrun ? '1 : '0;
    for (int c = 0; c < CHANNEL; c++) begin
      if (w_done && (w_done_ch == CW'(c)) && w_sat[16]) w_err_set[c] = 1'b1;
    end
  end

  // Output registers: hold each channel's value, strobe valid for one cycle
  always_ff @(posedge da_clk or posedge rst) begin
    if (rst) begin
      r_out     <= '0;
      r_out_vld <= '0;
    end else begin
      r_out_vld <= '0;
      for (int c = 0; c < CHANNEL; c++) begin
        if (w_done && (w_done_ch == CW'(c))) begin
          r_out[16*c +: 16] <= w_sat[15:0];
          r_out_vld[c]      <= 1'b1;
        end
      end
    end
  end

  // Sticky errors; a set in the same cycle as a clear keeps the bit set
  always_ff @(posedge da_clk or posedge rst) begin
    if (rst) r_err <= '0;
    else     r_err <= (r_err & ~err_clr) | w_err_set;
  end

  assign dac_pcm_out       = r_out;
  assign dac_pcm_out_valid = r_out_vld;
  assign err               = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dac_tx_tdm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dac_tx_tdm
//  Description : Self-checking bench for dac_tx_tdm with CHANNEL=2,
//                FREQ_NUM=2, MIX_NUM=2, SITA_W=16.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dac_tx_tdm;

  localparam int CH = 2;
  localparam int FN = 2;
  localparam int MN = 2;
  localparam int N  = CH * MN;

  logic        da_clk;
  logic        rst;
  logic [31:0] ipcm_in;
  logic [31:0] qpcm_in;
  logic        iqpcm_valid;
  logic [63:0] cos_sita;
  logic [63:0] sin_sita;
  logic [15:0] choose;
  logic [1:0]  err_clr;
  logic [31:0] dac_pcm_out;
  logic [1:0]  dac_pcm_out_valid;
  logic [1:0]  err;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] ip;
    logic [31:0] qp;
    logic [63:0] co;
    logic [63:0] si;
    logic [15:0] ch;
    logic [31:0] exp_out;
    logic [1:0]  exp_err;
  } vec_t;

  vec_t tbl[6];

  dac_tx_tdm #(
    .CHANNEL  (CH),
    .FREQ_NUM (FN),
    .MIX_NUM  (MN),
    .SITA_W   (16)
  ) dut (
    .da_clk            (da_clk),
    .rst               (rst),
    .ipcm_in           (ipcm_in),
    .qpcm_in           (qpcm_in),
    .iqpcm_valid       (iqpcm_valid),
    .cos_sita          (cos_sita),
    .sin_sita          (sin_sita),
    .choose            (choose),
    .err_clr           (err_clr),
    .dac_pcm_out       (dac_pcm_out),
    .dac_pcm_out_valid (dac_pcm_out_valid),
    .err               (err),
    .busy              (busy)
  );

  initial da_clk = 1'b0;
  always #5 da_clk = ~da_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge da_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: weighted sum per channel, floor-divide by 2^15, clamp
  function automatic void model(input vec_t v, output logic [31:0] out, output logic [1:0] clip);
    out  = '0;
    clip = '0;
    for (int c = 0; c < CH; c++) begin
      longint sum;
      longint q;
      sum = 0;
      for (int m = 0; m < MN; m++) begin
        int t;
        int sel;
        t   = c * MN + m;
        sel = int'(v.ch[4*t +: 4]);
        if (sel < FN) begin
          sum += longint'($signed(v.ip[16*sel +: 16])) * longint'($signed(v.co[16*t +: 16]))
               - longint'($signed(v.qp[16*sel +: 16])) * longint'($signed(v.si[16*t +: 16]));
        end
      end
      q = sum / 32768;
      if (sum < 0 && (sum % 32768) != 0) q = q - 1;
      if (q > 32767) begin
        q = 32767;
        clip[c] = 1'b1;
      end else if (q < -32768) begin
        q = -32768;
        clip[c] = 1'b1;
      end
      out[16*c +: 16] = q[15:0];
    end
  endfunction

  // Apply one sample at E0 and check every cycle up to E(N+2)
  task automatic run_sample(input vec_t v, input int ovr_edge, input int cfg_edge,
                            input logic [63:0] cos_new, input logic [1:0] clr_mask,
                            input int clr_until);
    ipcm_in     = v.ip;
    qpcm_in     = v.qp;
    cos_sita    = v.co;
    sin_sita    = v.si;
    choose      = v.ch;
    err_clr     = clr_mask;
    iqpcm_valid = 1'b1;
    tick();
    iqpcm_valid = 1'b0;
    if (clr_until == 0) err_clr = '0;
    chk("busy_E0", busy, 1);
    for (int t = 1; t <= N + 2; t++) begin
      if (t == ovr_edge) begin
        iqpcm_valid = 1'b1;
        ipcm_in     = ~ipcm_in;
      end
      if (t == cfg_edge) cos_sita = cos_new;
      tick();
      iqpcm_valid = 1'b0;
      if (t == clr_until) begin
        chk($sformatf("err_set_wins_E%0d", t), err & clr_mask, clr_mask);
        err_clr = '0;
      end
      if (t == ovr_edge) chk("err_overrun", err, 2'b11);
      for (int c = 0; c < CH; c++) begin
        logic ev;
        ev = (t == c * MN + MN + 2);
        chk($sformatf("valid%0d_E%0d", c, t), dac_pcm_out_valid[c], ev);
        if (ev) chk($sformatf("out%0d", c), dac_pcm_out[16*c +: 16], v.exp_out[16*c +: 16]);
      end
      chk($sformatf("busy_E%0d", t), busy, (t < N + 2));
    end
    chk("err_after", err, v.exp_err);
  endtask

  task automatic clear_err();
    err_clr = 2'b11;
    tick();
    err_clr = 2'b00;
    chk("err_cleared", err, 0);
  endtask

  function automatic logic [15:0] rnd16();
    logic [31:0] r;
    r = $urandom;
    if (r[31]) return {{6{r[9]}}, r[9:0]};
    return r[15:0];
  endfunction

  initial begin
    vec_t        v;
    logic [31:0] mout;
    logic [1:0]  mclip;
    logic [1:0]  err_acc;

    // I0=1000, ch0 term0 f0 cos=0.5; everything else disabled
    tbl[0] = '{ip: 32'h0000_03E8, qp: 32'h0, co: 64'h0000_0000_0000_4000, si: 64'h0,
               ch: 16'hFFF0, exp_out: 32'h0000_01F4, exp_err: 2'b00};
    // Q path: Q1=1000, ch1 term choose=1, sin=-0.5 -> +500
    tbl[1] = '{ip: 32'h0, qp: 32'h03E8_0000, co: 64'h0, si: 64'h0000_C000_0000_0000,
               ch: 16'hF1FF, exp_out: 32'h01F4_0000, exp_err: 2'b00};
    // same with sin=+0.5 -> -500
    tbl[2] = '{ip: 32'h0, qp: 32'h03E8_0000, co: 64'h0, si: 64'h0000_4000_0000_0000,
               ch: 16'hF1FF, exp_out: 32'hFE0C_0000, exp_err: 2'b00};
    // ch0 two terms 30000*32767 -> positive clip
    tbl[3] = '{ip: 32'h0000_7530, qp: 32'h0, co: 64'h0000_0000_7FFF_7FFF, si: 64'h0,
               ch: 16'hFF00, exp_out: 32'h0000_7FFF, exp_err: 2'b01};
    // ch0 -3*0.5 floors to -2; ch1 (-1)*(-1) -> 32768 clips to 32767
    tbl[4] = '{ip: 32'h8000_FFFD, qp: 32'h0, co: 64'h0000_8000_0000_4000, si: 64'h0,
               ch: 16'hF1F0, exp_out: 32'h7FFF_FFFE, exp_err: 2'b10};
    // ch0 two -Q*sin terms -> negative clip
    tbl[5] = '{ip: 32'h0, qp: 32'h7FFF_0000, co: 64'h0, si: 64'h0000_0000_7FFF_7FFF,
               ch: 16'hFF11, exp_out: 32'h0000_8000, exp_err: 2'b01};

    rst         = 1'b1;
    ipcm_in     = '0;
    qpcm_in     = '0;
    iqpcm_valid = 1'b0;
    cos_sita    = '0;
    sin_sita    = '0;
    choose      = '0;
    err_clr     = '0;
    tick();
    tick();
    chk("rst_out", dac_pcm_out, 0);
    chk("rst_valid", dac_pcm_out_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    tick();

    // Table vectors, each followed by a clear of the sticky errors
    for (int i = 0; i < 6; i++) begin
      run_sample(tbl[i], 0, 0, 64'h0, 2'b00, 0);
      clear_err();
    end

    // Clear held while the saturation error sets: set wins
    run_sample(tbl[3], 0, 0, 64'h0, 2'b01, 4);
    clear_err();

    // Overrun at E2: error on every channel, first sample unaffected, no third burst
    v = tbl[0];
    v.exp_err = 2'b11;
    run_sample(v, 2, 0, 64'h0, 2'b00, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("overrun_no_burst", dac_pcm_out_valid, 0);
      chk("overrun_idle", busy, 0);
    end
    chk("out_held", dac_pcm_out, 32'h0000_01F4);
    clear_err();

    // Shadowing: cos changed at E1 only affects the following sample
    run_sample(tbl[0], 0, 1, 64'h0000_0000_0000_2000, 2'b00, 0);
    v = tbl[0];
    v.co = 64'h0000_0000_0000_2000;
    v.exp_out = 32'h0000_00FA;
    run_sample(v, 0, 0, 64'h0, 2'b00, 0);

    // Reset at E3 (with an overrun error pending) aborts the sample cleanly
    ipcm_in     = tbl[0].ip;
    qpcm_in     = tbl[0].qp;
    cos_sita    = tbl[0].co;
    sin_sita    = tbl[0].si;
    choose      = tbl[0].ch;
    iqpcm_valid = 1'b1;
    tick();
    iqpcm_valid = 1'b0;
    tick();
    iqpcm_valid = 1'b1;
    tick();
    iqpcm_valid = 1'b0;
    chk("pre_rst_err", err, 2'b11);
    tick();
    rst = 1'b1;
    #1;
    chk("midrst_out", dac_pcm_out, 0);
    chk("midrst_valid", dac_pcm_out_valid, 0);
    chk("midrst_err", err, 0);
    chk("midrst_busy", busy, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("post_rst_valid", dac_pcm_out_valid, 0);
      chk("post_rst_busy", busy, 0);
    end
    run_sample(tbl[0], 0, 0, 64'h0, 2'b00, 0);

    // Randomized samples against the model, back to back, sticky errors tracked
    err_acc = err;
    for (int n = 0; n < 40; n++) begin
      v.ip = {rnd16(), rnd16()};
      v.qp = {rnd16(), rnd16()};
      v.co = {rnd16(), rnd16(), rnd16(), rnd16()};
      v.si = {rnd16(), rnd16(), rnd16(), rnd16()};
      for (int t = 0; t < N; t++) begin
        int r;
        r = int'($urandom_range(0, 4));
        v.ch[4*t +: 4] = (r == 4) ? 4'hF : 4'(r);
      end
      model(v, mout, mclip);
      v.exp_out = mout;
      err_acc   = err_acc | mclip;
      v.exp_err = err_acc;
      run_sample(v, 0, 0, 64'h0, 2'b00, 0);
      if ($urandom_range(0, 2) == 0) begin
        clear_err();
        err_acc = 2'b00;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
